// File: rtl/regfile.sv
// regfile: 32 x WIDTH MIPS general-purpose register file.
// Two combinational operand read ports (rs -> ALU a, rt -> ALU b / imm mux),
// one write port committed on the rising clock edge, and a debug read port
// that always shows committed architectural state. Entry 0 is hard-wired
// to zero. Optional write-through forwarding on the operand ports only.
module regfile #(
    parameter int WIDTH  = 32,
    parameter bit BYPASS = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       read1,
    input  logic [4:0]       read2,
    input  logic [4:0]       dbg_read,
    input  logic             regwrite,
    input  logic [4:0]       wrreg,
    input  logic [WIDTH-1:0] wrdata,
    output logic [WIDTH-1:0] data1,
    output logic [WIDTH-1:0] data2,
    output logic [WIDTH-1:0] dbg_data
);

    // Architectural storage. Entry 0 is cleared by reset and never written,
    // so it stays zero; the read muxes also force address 0 to zero.
    logic [WIDTH-1:0] regs_r [0:31];

    logic             fwd1_s;
    logic             fwd2_s;
    logic [WIDTH-1:0] data1_s;
    logic [WIDTH-1:0] data2_s;
    logic [WIDTH-1:0] dbg_data_s;

    // Read-port selection: reset and address 0 force zero, a forwarded
    // write wins next, otherwise the committed entry is returned.
    function automatic logic [WIDTH-1:0] port_mux(
        input logic             rst_i,
        input logic [4:0]       addr,
        input logic             fwd,
        input logic [WIDTH-1:0] stored,
        input logic [WIDTH-1:0] wdata
    );
        logic [WIDTH-1:0] result;
        if (rst_i) begin
            result = {WIDTH{1'b0}};
        end else if (addr == 5'd0) begin
            result = {WIDTH{1'b0}};
        end else if (fwd) begin
            result = wdata;
        end else begin
            result = stored;
        end
        return result;
    endfunction

    // Write port: async clear of every entry, otherwise commit a non-zero
    // destination when write enable is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
        end else if (regwrite && (wrreg != 5'd0)) begin
            regs_r[wrreg] <= wrdata;
        end else begin
            regs_r[0] <= {WIDTH{1'b0}};
        end
    end

    // Forwarding hits: only built when BYPASS is enabled, never for r0.
    always_comb begin
        fwd1_s = 1'b0;
        fwd2_s = 1'b0;
        if (BYPASS == 1'b1) begin
            fwd1_s = regwrite && (wrreg != 5'd0) && (wrreg == read1);
            fwd2_s = regwrite && (wrreg != 5'd0) && (wrreg == read2);
        end else begin
            fwd1_s = 1'b0;
            fwd2_s = 1'b0;
        end
    end

    // Combinational read muxes; the debug port never forwards.
    always_comb begin
        data1_s    = {WIDTH{1'b0}};
        data2_s    = {WIDTH{1'b0}};
        dbg_data_s = {WIDTH{1'b0}};
        data1_s    = port_mux(rst, read1,    fwd1_s, regs_r[read1],    wrdata);
        data2_s    = port_mux(rst, read2,    fwd2_s, regs_r[read2],    wrdata);
        dbg_data_s = port_mux(rst, dbg_read, 1'b0,   regs_r[dbg_read], wrdata);
    end

    assign data1    = data1_s;
    assign data2    = data2_s;
    assign dbg_data = dbg_data_s;

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed + randomized checks of regfile, with one instance
// built without forwarding and one with forwarding, sharing all inputs.
// Expected values go into a scoreboard queue when stimulus is applied and
// are popped and compared once the outputs have settled.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic [4:0]  read1;
    logic [4:0]  read2;
    logic [4:0]  dbg_read;
    logic        regwrite;
    logic [4:0]  wrreg;
    logic [31:0] wrdata;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] dbg_data;
    logic [31:0] b_data1;
    logic [31:0] b_data2;
    logic [31:0] b_dbg_data;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        int          port;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    logic [31:0] model [0:31];

    regfile #(.WIDTH(32), .BYPASS(1'b0)) dut (
        .clk(clk), .rst(rst), .read1(read1), .read2(read2),
        .dbg_read(dbg_read), .regwrite(regwrite), .wrreg(wrreg),
        .wrdata(wrdata), .data1(data1), .data2(data2), .dbg_data(dbg_data)
    );

    regfile #(.WIDTH(32), .BYPASS(1'b1)) dut_byp (
        .clk(clk), .rst(rst), .read1(read1), .read2(read2),
        .dbg_read(dbg_read), .regwrite(regwrite), .wrreg(wrreg),
        .wrdata(wrdata), .data1(b_data1), .data2(b_data2), .dbg_data(b_dbg_data)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Port selector: 0..2 = plain data1/data2/dbg, 3..5 = forwarding instance.
    function automatic logic [31:0] obs(input int p);
        case (p)
            0: return data1;
            1: return data2;
            2: return dbg_data;
            3: return b_data1;
            4: return b_data2;
            5: return b_dbg_data;
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic push(input string tag, input int port, input logic [31:0] v);
        exp_t e;
        e.tag  = tag;
        e.port = port;
        e.val  = v;
        sb.push_back(e);
    endtask

    // Expect the same value on both instances for one port.
    task automatic push2(input string tag, input int port, input logic [31:0] v);
        push(tag, port, v);
        push(tag, port + 3, v);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.port);
            n_assert++;
            assert (o === e.val) else begin
                n_fail++;
                $error("FAIL %s port%0d: observed %h expected %h", e.tag, e.port, o, e.val);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  ra;
        logic [4:0]  wa;
        logic [31:0] wd;

        rst = 1'b0; read1 = 5'd7; read2 = 5'd20; dbg_read = 5'd0;
        regwrite = 1'b0; wrreg = 5'd0; wrdata = 32'h0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        // Reset asserted between edges: everything reads zero before posedge.
        #3 rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            dbg_read = i[4:0];
            #1;
            push2($sformatf("rst_dbg_r%0d", i), 2, 32'h0);
            drain();
        end
        push2("rst_d1", 0, 32'h0);
        push2("rst_d2", 1, 32'h0);
        drain();

        // Write r5 then r31 on successive edges, starting right after release.
        @(negedge clk);
        rst = 1'b0; regwrite = 1'b1; wrreg = 5'd5; wrdata = 32'hdeadbeef;
        @(negedge clk);
        wrreg = 5'd31; wrdata = 32'h0000_0007;
        @(negedge clk);
        regwrite = 1'b0; read1 = 5'd5; read2 = 5'd31; dbg_read = 5'd5;
        model[5] = 32'hdeadbeef; model[31] = 32'h0000_0007;
        #1;
        push2("wr_d1_r5", 0, 32'hdeadbeef);
        push2("wr_d2_r31", 1, 32'h0000_0007);
        push2("wr_dbg_r5", 2, 32'hdeadbeef);
        drain();

        // $zero: write to r0 is a no-op, even with forwarding enabled.
        @(negedge clk);
        regwrite = 1'b1; wrreg = 5'd0; wrdata = 32'hffffffff;
        read1 = 5'd0; read2 = 5'd0; dbg_read = 5'd0;
        #1;
        push2("zero_pre_d1", 0, 32'h0);
        drain();
        @(negedge clk);
        regwrite = 1'b0;
        #1;
        push2("zero_d1", 0, 32'h0);
        push2("zero_d2", 1, 32'h0);
        push2("zero_dbg", 2, 32'h0);
        drain();

        // Same-cycle read/write of r8 (holds 3, then written with 9).
        @(negedge clk);
        regwrite = 1'b1; wrreg = 5'd8; wrdata = 32'd3;
        @(negedge clk);
        wrdata = 32'd9; read1 = 5'd8; read2 = 5'd8; dbg_read = 5'd8;
        #1;
        push("rw_old_d1", 0, 32'd3);
        push("rw_old_d2", 1, 32'd3);
        push("rw_old_dbg", 2, 32'd3);
        push("rw_fwd_d1", 3, 32'd9);
        push("rw_fwd_d2", 4, 32'd9);
        push("rw_fwd_dbg", 5, 32'd3);
        drain();
        @(posedge clk);
        #1;
        regwrite = 1'b0;
        #1;
        push2("rw_new_d1", 0, 32'd9);
        push2("rw_new_dbg", 2, 32'd9);
        drain();
        model[8] = 32'd9;

        // Back-to-back writes to r10: each value visible for one cycle.
        @(negedge clk);
        regwrite = 1'b1; wrreg = 5'd10; wrdata = 32'h0000_00a1;
        read1 = 5'd10; dbg_read = 5'd10;
        @(posedge clk);
        #1;
        push2("b2b_first", 2, 32'h0000_00a1);
        push("b2b_first_d1", 0, 32'h0000_00a1);
        drain();
        wrdata = 32'h0000_00a2;
        @(posedge clk);
        #1;
        regwrite = 1'b0;
        #1;
        push2("b2b_last", 0, 32'h0000_00a2);
        push2("b2b_last_dbg", 2, 32'h0000_00a2);
        drain();
        model[10] = 32'h0000_00a2;

        // Write disabled, then X on address/data while disabled.
        @(negedge clk);
        regwrite = 1'b0; wrreg = 5'd12; wrdata = 32'd55;
        @(negedge clk);
        wrreg = 5'bxxxxx; wrdata = 32'hxxxx_xxxx;
        @(negedge clk);
        wrreg = 5'd0; wrdata = 32'h0;
        read1 = 5'd5; read2 = 5'd31; dbg_read = 5'd12;
        #1;
        push2("wdis_r12", 2, 32'h0);
        push2("wdis_r5", 0, 32'hdeadbeef);
        push2("wdis_r31", 1, 32'h0000_0007);
        drain();

        // Randomized writes against a reference array.
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            wa = 5'($urandom_range(0, 31));
            ra = 5'($urandom_range(0, 31));
            wd = $urandom;
            if (k % 4 == 0) ra = wa;
            regwrite = 1'b1; wrreg = wa; wrdata = wd; read1 = ra; read2 = wa;
            dbg_read = ra;
            #1;
            push($sformatf("rnd%0d_d1", k), 0, model[ra]);
            push($sformatf("rnd%0d_d2", k), 1, model[wa]);
            push($sformatf("rnd%0d_dbg", k), 5, model[ra]);
            push($sformatf("rnd%0d_fd1", k), 3,
                 ((ra == wa) && (wa != 5'd0)) ? wd : model[ra]);
            push($sformatf("rnd%0d_fd2", k), 4, (wa != 5'd0) ? wd : 32'h0);
            drain();
            @(posedge clk);
            if (wa != 5'd0) model[wa] = wd;
        end
        @(negedge clk);
        regwrite = 1'b0;

        // Reset during a write: r3=100, then write 200 with rst high.
        @(negedge clk);
        regwrite = 1'b1; wrreg = 5'd3; wrdata = 32'd100;
        @(negedge clk);
        regwrite = 1'b0; read1 = 5'd3; read2 = 5'd3; dbg_read = 5'd3;
        #1;
        push2("rstw_pre", 0, 32'd100);
        drain();
        @(negedge clk);
        rst = 1'b1; regwrite = 1'b1; wrreg = 5'd3; wrdata = 32'd200;
        #1;
        push2("rstw_now_d1", 0, 32'h0);
        push2("rstw_now_d2", 1, 32'h0);
        push2("rstw_now_dbg", 2, 32'h0);
        drain();
        @(negedge clk);
        rst = 1'b0; regwrite = 1'b0; read2 = 5'd5;
        #1;
        push2("rstw_r3", 0, 32'h0);
        push2("rstw_r5_lost", 1, 32'h0);
        drain();
        @(negedge clk);
        regwrite = 1'b1; wrreg = 5'd3; wrdata = 32'd200;
        @(negedge clk);
        regwrite = 1'b0;
        #1;
        push2("rstw_after", 0, 32'd200);
        push2("rstw_after_dbg", 2, 32'd200);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
